// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int DEPTH_DEF      = 16;
  localparam int ADDR_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  // Owner index encoding used for the latched owner and the arbiter winner.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// Bundle of both master request/response channels plus the memory port.
// Latency: n/a (wires only).
// Backpressure: masters hold req and fields stable until their gnt pulse.
interface dmem_arb_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  // Master 0 (CPU load/store stage)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [ADDR_W-1:0] m0_rdata;
  logic              m0_err;

  // Master 1 (debug/DMA loader)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [ADDR_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [ADDR_W-1:0] m1_rdata;
  logic              m1_err;

  // Single-port memory (writes on negedge, combinational read)
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  // Requester / memory-model side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_prio.sv
// Picks the winner between m0 and m1 whenever the sequencer is IDLE.
// Latency: combinational winner; priority state updates at posedge.
// Backpressure: none; losing master simply keeps requesting. Macro DMEM_ARB_RR_EN selects round-robin.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_i,
  input  logic m0_req_i,
  input  logic m1_req_i,
  output logic win_o,
  output logic gnt_vld_o
);

`ifdef DMEM_ARB_RR_EN

  // Owner of the most recent grant; starts at M1 so m0 wins the first tie.
  logic last_q, last_d;

  // Tie goes to whichever master was not granted last.
  always_comb begin
    gnt_vld_o = idle_i & (m0_req_i | m1_req_i);
    last_d    = last_q;
    if (m0_req_i && m1_req_i) begin
      win_o = (last_q == M1) ? M0 : M1;
    end else begin
      win_o = m1_req_i ? M1 : M0;
    end
    if (gnt_vld_o) begin
      last_d = win_o;
    end
  end

  // Last-owner pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= M1;
    end else begin
      last_q <= last_d;
    end
  end

`else

  // Number of consecutive IDLE cycles m1 lost to m0; saturates at 7.
  logic [2:0] m1_wait_q, m1_wait_d;
  logic       starve;

  assign starve = (m1_wait_q == 3'(STARVE_MAX));

  // Fixed priority to m0 unless m1 has been starved long enough.
  always_comb begin
    gnt_vld_o = idle_i & (m0_req_i | m1_req_i);
    win_o     = M0;
    if (m1_req_i && (!m0_req_i || starve)) begin
      win_o = M1;
    end
    m1_wait_d = m1_wait_q;
    if (!m1_req_i) begin
      m1_wait_d = 3'd0;
    end else if (gnt_vld_o && (win_o == M1)) begin
      m1_wait_d = 3'd0;
    end else if (gnt_vld_o && (m1_wait_q != 3'd7)) begin
      m1_wait_d = m1_wait_q + 3'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_wait_q <= 3'd0;
    end else begin
      m1_wait_q <= m1_wait_d;
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer in front of a 16-word single-port data memory.
// Latency: gnt in cycle N, memory strobe in N+1, registered rvalid/rdata/err in N+2.
// Backpressure: one access per 2 cycles; losers hold req until their gnt pulse.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_arb_if.slave  bus
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;

  logic              rvalid0_q, rvalid1_q;
  logic              err0_q, err1_q;
  logic [ADDR_W-1:0] rdata0_q, rdata1_q;

  logic              idle;
  logic              win;
  logic              gnt_vld;
  logic              in_range;
  logic              access;
  logic [ADDR_W-1:0] resp_data;

  logic              m0_gnt, m1_gnt;
  logic [ADDR_W-1:0] mem_addr, mem_wdata;
  logic              mem_write, mem_read;

  assign idle     = (state_q == IDLE);
  assign access   = (state_q == ACCESS);
  assign in_range = (addr_q < ADDR_W'(DEPTH));
  // Writes and out-of-range accesses return zero data.
  assign resp_data = (!we_q && in_range) ? bus.mem_rdata : '0;

  dmem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle_i    (idle),
    .m0_req_i  (bus.m0_req),
    .m1_req_i  (bus.m1_req),
    .win_o     (win),
    .gnt_vld_o (gnt_vld)
  );

  // Next-state, request latch and memory strobes; strobes depend only on state_q so reset kills them at once.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          m0_gnt  = (win == M0);
          m1_gnt  = (win == M1);
          owner_d = win;
          we_d    = (win == M1) ? bus.m1_we    : bus.m0_we;
          addr_d  = (win == M1) ? bus.m1_addr  : bus.m0_addr;
          wdata_d = (win == M1) ? bus.m1_wdata : bus.m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_write = we_q & in_range;
        mem_read  = ~we_q & in_range;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latched request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Registered response to the owner; rdata holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= access && (owner_q == M0);
      rvalid1_q <= access && (owner_q == M1);
      err0_q    <= access && (owner_q == M0) && !in_range;
      err1_q    <= access && (owner_q == M1) && !in_range;
      if (access && (owner_q == M0)) begin
        rdata0_q <= resp_data;
      end
      if (access && (owner_q == M1)) begin
        rdata1_q <= resp_data;
      end
    end
  end

  assign bus.m0_gnt    = m0_gnt;
  assign bus.m1_gnt    = m1_gnt;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_err    = err0_q;
  assign bus.m1_err    = err1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_write = mem_write;
  assign bus.mem_read  = mem_read;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 16-word negedge-write memory model.
// Inputs are driven 1 time unit after posedge, outputs sampled 4 units after posedge.
// Honours DMEM_ARB_RR_EN for the arbitration-order expectations.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  logic preload;
  logic [31:0] mem [16];

  int n_chk;
  int n_fail;
  int gq [$];
  int exp_order [6];

  dmem_arb_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes on negedge, combinational read.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 32'h0;
      end
      mem[1] <= 32'h0000_0011;
      mem[2] <= 32'h0000_0022;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outputs(input string tag);
    check({tag, "_m0_gnt"},    {31'd0, bus.m0_gnt},    32'd0);
    check({tag, "_m1_gnt"},    {31'd0, bus.m1_gnt},    32'd0);
    check({tag, "_mem_write"}, {31'd0, bus.mem_write}, 32'd0);
    check({tag, "_mem_read"},  {31'd0, bus.mem_read},  32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr,           32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,          32'd0);
    check({tag, "_m0_rvalid"}, {31'd0, bus.m0_rvalid}, 32'd0);
    check({tag, "_m1_rvalid"}, {31'd0, bus.m1_rvalid}, 32'd0);
    check({tag, "_m0_err"},    {31'd0, bus.m0_err},    32'd0);
    check({tag, "_m0_rdata"},  bus.m0_rdata,           32'd0);
    check({tag, "_m1_rdata"},  bus.m1_rdata,           32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    preload = 1'b1;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

    // Reset state
    repeat (2) step();
    #3;
    idle_outputs("rst");
    step();
    preload = 1'b0;
    rst_n = 1'b1;

    // m0 write addr 3 then read it back
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'd3; bus.m0_wdata = 32'hDEAD_BEEF;
    #3;
    check("wr_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    check("wr_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    check("wr_memw_n", {31'd0, bus.mem_write}, 32'd0);
    step();
    bus.m0_req = 1'b0;
    #3;
    check("wr_memw", {31'd0, bus.mem_write}, 32'd1);
    check("wr_memr", {31'd0, bus.mem_read}, 32'd0);
    check("wr_addr", bus.mem_addr, 32'd3);
    check("wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("wr_rv_early", {31'd0, bus.m0_rvalid}, 32'd0);
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd3; bus.m0_wdata = '0;
    #3;
    check("wr_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    check("wr_err", {31'd0, bus.m0_err}, 32'd0);
    check("wr_rdata0", bus.m0_rdata, 32'd0);
    check("wr_memw_one", {31'd0, bus.mem_write}, 32'd0);
    check("wr_mem3", mem[3], 32'hDEAD_BEEF);
    check("rd_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    step();
    bus.m0_req = 1'b0;
    #3;
    check("rd_memr", {31'd0, bus.mem_read}, 32'd1);
    check("rd_memw", {31'd0, bus.mem_write}, 32'd0);
    check("rd_addr", bus.mem_addr, 32'd3);
    step();
    #3;
    check("rd_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    check("rd_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    check("rd_err", {31'd0, bus.m0_err}, 32'd0);
    step();
    #3;
    check("rd_rv_drop", {31'd0, bus.m0_rvalid}, 32'd0);
    check("rd_hold", bus.m0_rdata, 32'hDEAD_BEEF);

    // Back-to-back m0 reads of addr 1 and 2
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd1;
    #3;
    check("b2b_gnt0", {31'd0, bus.m0_gnt}, 32'd1);
    step();
    bus.m0_addr = 32'd2;
    #3;
    check("b2b_gnt1_n", {31'd0, bus.m0_gnt}, 32'd0);
    check("b2b_addr1", bus.mem_addr, 32'd1);
    step();
    #3;
    check("b2b_gnt2", {31'd0, bus.m0_gnt}, 32'd1);
    check("b2b_rv2", {31'd0, bus.m0_rvalid}, 32'd1);
    check("b2b_rd2", bus.m0_rdata, 32'h11);
    step();
    bus.m0_req = 1'b0;
    #3;
    check("b2b_addr2", bus.mem_addr, 32'd2);
    check("b2b_rv3", {31'd0, bus.m0_rvalid}, 32'd0);
    step();
    #3;
    check("b2b_rv4", {31'd0, bus.m0_rvalid}, 32'd1);
    check("b2b_rd4", bus.m0_rdata, 32'h22);

    // m1 out-of-range write to addr 16
    step();
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'd16; bus.m1_wdata = 32'd5;
    #3;
    check("oor_gnt", {31'd0, bus.m1_gnt}, 32'd1);
    check("oor_m0_gnt", {31'd0, bus.m0_gnt}, 32'd0);
    step();
    bus.m1_req = 1'b0;
    #3;
    check("oor_memw", {31'd0, bus.mem_write}, 32'd0);
    check("oor_memr", {31'd0, bus.mem_read}, 32'd0);
    step();
    #3;
    check("oor_rvalid", {31'd0, bus.m1_rvalid}, 32'd1);
    check("oor_err", {31'd0, bus.m1_err}, 32'd1);
    check("oor_rdata", bus.m1_rdata, 32'd0);
    check("oor_m0_rv", {31'd0, bus.m0_rvalid}, 32'd0);
    check("oor_mem0", mem[0], 32'd0);
    check("oor_mem3", mem[3], 32'hDEAD_BEEF);

    // Reset in the middle of an m0 write to addr 5
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'd5; bus.m0_wdata = 32'd7;
    #3;
    check("rsta_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    step();
    bus.m0_req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rsta_memw", {31'd0, bus.mem_write}, 32'd0);
    check("rsta_addr", bus.mem_addr, 32'd0);
    step();
    #3;
    check("rsta_rv", {31'd0, bus.m0_rvalid}, 32'd0);
    check("rsta_mem5", mem[5], 32'd0);
    step();
    rst_n = 1'b1;
    #3;
    idle_outputs("rsta_post");

    // m1 pulses one cycle while m0 is granted, then drops
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd2;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd4;
    #3;
    check("pulse_m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    check("pulse_m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
    step();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    #3;
    check("pulse_m1_gnt2", {31'd0, bus.m1_gnt}, 32'd0);
    step();

    // Both masters request continuously; record grant order
`ifdef DMEM_ARB_RR_EN
    exp_order = '{1, 0, 1, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 0, 1, 0};
`endif
    step();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd0;
    for (int c = 0; c < 14; c++) begin
      #3;
      check("arb_onehot", {31'd0, bus.m0_gnt & bus.m1_gnt}, 32'd0);
      if (bus.m0_gnt) gq.push_back(0);
      if (bus.m1_gnt) gq.push_back(1);
      step();
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    check("arb_ngrants", gq.size(), 32'd7);
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size()) begin
        check($sformatf("arb_order%0d", i), gq[i], exp_order[i]);
      end else begin
        check($sformatf("arb_order%0d_missing", i), 32'hFFFF_FFFF, exp_order[i]);
      end
    end

    // Quiet after traffic
    repeat (3) step();
    #3;
    check("end_memw", {31'd0, bus.mem_write}, 32'd0);
    check("end_memr", {31'd0, bus.mem_read}, 32'd0);
    check("end_addr", bus.mem_addr, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port 16-word data memory. The memory writes on negedge clk and reads combinationally.
- Master 0 is the CPU load/store stage. Master 1 is the debug/DMA loader.
- Accepts one request at a time, drives the memory's address, write-data, write-enable and read-enable for exactly one cycle, and returns a registered response to the owning master.

Parameters:
- ADDR_W, 32, width of master/memory address and data.
- DEPTH, 16, memory words; addresses >= DEPTH are out of range.
- STARVE_MAX, 4, consecutive lost arbitration cycles after which m1 overrides m0.

Ports:
- clk  in  1  system clock, posedge sequencing.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 request; held with fields stable until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  ADDR_W  write data.
- m0_gnt  out  1  one-cycle pulse: request accepted this cycle.
- m0_rvalid  out  1  one-cycle response pulse.
- m0_rdata  out  ADDR_W  read data, valid with m0_rvalid.
- m0_err  out  1  out-of-range flag, valid with m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical set for master 1.
- mem_addr  out  ADDR_W  to memory Addr.
- mem_wdata  out  ADDR_W  to memory WriteData.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_rdata  in  ADDR_W  from memory ReadData.

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- FSM: IDLE, ACCESS.
- IDLE:
  - If any req is high, the winner's gnt is asserted combinationally in the same cycle.
  - At the posedge, owner, we, addr and wdata are latched and the FSM goes to ACCESS.
  - With no req, the FSM stays in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_write = latched we and in-range.
  - mem_read = !we and in-range.
  - The memory writes at this cycle's negedge.
  - At the posedge, mem_rdata is captured (0 for writes or out-of-range), the owner's rvalid is set for 1 cycle, err = out-of-range, and the FSM returns to IDLE.
- Latency: gnt in cycle N, memory access in cycle N+1, rvalid/rdata in cycle N+2. Throughput is 1 access per 2 cycles. A new gnt may coincide with the previous rvalid.
- rdata holds its last value between rvalid pulses. err and rvalid are 0 otherwise.
- mem_write and mem_read are 0 outside ACCESS. mem_addr and mem_wdata are 0 in IDLE.
- Range: out of range means addr >= DEPTH, compared over the full ADDR_W bits. No memory strobe is issued, but the response still occurs with err=1 and rdata=0.
- Priority (default):
  - m0 wins ties.
  - Counter m1_wait (3 bits, saturating) increments on each IDLE cycle where m1_req=1 and m0 is granted.
  - m1_wait clears on m1 grant or when m1_req=0.
  - When m1_wait == STARVE_MAX, m1 wins the next IDLE tie.
- Request withdrawn before gnt: no effect and legal. req held high after gnt is treated as a new request at the next IDLE.
- Reset:
  - All outputs, FSM (to IDLE), latched fields and m1_wait go to 0 immediately.
  - A transaction in ACCESS is dropped: mem_write falls asynchronously, so no write occurs at the following negedge.
  - No rvalid is issued for a dropped transaction.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-owner pointer gives the tie to the master not granted last. The pointer resets to 1, so m0 wins the first tie. m1_wait and STARVE_MAX are unused.
- Undefined: fixed priority with the starvation override described above.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, ACCESS}.
  - constants DEPTH_DEF=16, ADDR_W_DEF=32, STARVE_MAX_DEF=4.
  - owner index constants M0=0, M1=1.
- Sub-module dmem_arb_prio: takes both reqs and the IDLE qualifier, outputs the winner and a grant-valid signal. It contains m1_wait or, under DMEM_ARB_RR_EN, the round-robin pointer.

Test Plan:
- m0 write addr=3 data=0xDEADBEEF, then m0 read addr=3 -> mem_write=1 for exactly one cycle; read m0_rvalid at N+2 with m0_rdata=0xDEADBEEF, m0_err=0.
- Both masters read every cycle, STARVE_MAX=4 -> grant order m0,m0,m0,m0,m1,m0…; with DMEM_ARB_RR_EN the order is m0,m1,m0,m1.
- m1 write addr=16 data=5 -> no mem_write or mem_read pulse; m1_rvalid=1 with m1_err=1, m1_rdata=0; mem[0..15] unchanged.
- Back-to-back m0 reads of addr 1 and 2 -> gnt in cycles 0 and 2, rvalid in cycles 2 and 4; the second gnt coincides with the first rvalid.
- rst_n asserted low mid-ACCESS of m0 write addr=5 data=7 -> mem_write drops immediately, mem[5] stays 0, no rvalid; after release the FSM is IDLE and all outputs are 0.
- m1_req pulses for 1 cycle while m0 is being granted, then drops -> no m1 gnt, m1_wait returns to 0.
